// File: rtl/silencer_pkg.sv
// Shared silencer package: scheduler state encoding, address/beat widths and
// the completion-steps clamp helper.
package silencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } sched_state_t;

    localparam int AddrWidth    = 8;
    localparam int BeatCntWidth = 9;

    // Zero steps would make the calculator divide by zero, so clamp to 1.
    function automatic logic [15:0] clamp_steps(input logic [15:0] value);
        return (value == '0) ? 16'd1 : value;
    endfunction

endpackage

// File: rtl/silencer_frame_timeout.sv
// Loadable down-counter that flags expiry once it has counted load_value
// cycles after being loaded; stop disarms it.
module silencer_frame_timeout #(
    parameter int Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    input  logic             stop,
    output logic             expire
);

    logic [Width-1:0] count;
    logic             running;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= load_value;
            running <= 1'b1;
        end else if (stop) begin
            running <= 1'b0;
        end else if (running && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = running && (count == '0);

endmodule

// File: rtl/silencer_step_scheduler.sv
// Frame scheduler feeding the silencer step calculator from the intensity source.
// Optional SILENCER_OVERRUN_COUNT_EN adds a saturating dropped-request counter.
module silencer_step_scheduler
    import silencer_pkg::*;
#(
    parameter int DEPTH          = 249,
    parameter int TIMEOUT_MARGIN = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 UPDATE,
    input  logic                 CONFIG_VALID,
    input  logic [15:0]          COMPLETION_STEPS,
    output logic [AddrWidth-1:0] SRC_ADDR,
    input  logic [15:0]          SRC_DATA,
    output logic                 CALC_DIN_VALID,
    output logic [15:0]          CALC_COMPLETION_STEPS,
    output logic [15:0]          CALC_INTENSITY,
    input  logic                 CALC_DOUT_VALID,
    output logic                 BUSY,
    output logic                 FRAME_DONE,
    output logic                 TIMEOUT
`ifdef SILENCER_OVERRUN_COUNT_EN
    ,
    output logic [15:0]          OVERRUN_COUNT
`endif
);

    localparam logic [AddrWidth-1:0]    LastAddr    = AddrWidth'(DEPTH - 1);
    localparam logic [BeatCntWidth-1:0] DepthBeats  = BeatCntWidth'(DEPTH);
    localparam logic [15:0]             TimeoutLoad = 16'(DEPTH + TIMEOUT_MARGIN);

    sched_state_t            state;
    sched_state_t            state_next;
    logic                    start;
    logic                    pending;
    logic [15:0]             shadow_steps;
    logic                    fetch_d1;
    logic                    first_d1;
    logic [BeatCntWidth-1:0] beat_cnt;
    logic                    beats_complete;
    logic                    expire;
    logic                    timer_stop;

    assign beats_complete = (beat_cnt == DepthBeats);

    always_comb begin
        state_next = state;
        start      = 1'b0;
        unique case (state)
            IDLE: begin
                if (UPDATE || pending) begin
                    state_next = FETCH;
                    start      = 1'b1;
                end
            end
            FETCH: begin
                if (SRC_ADDR == LastAddr) state_next = DRAIN;
            end
            DRAIN: begin
                if (beats_complete) state_next = DONE;
                else if (expire)    state_next = IDLE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign BUSY       = (state != IDLE);
    assign FRAME_DONE = (state == DONE);
    assign TIMEOUT    = (state == DRAIN) && expire && !beats_complete;
    assign timer_stop = (state == DONE) || TIMEOUT;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge CLK) begin
        if (RST)                          pending <= 1'b0;
        else if (start)                   pending <= 1'b0;
        else if (UPDATE && state != IDLE) pending <= 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow_steps          <= 16'd1;
            CALC_COMPLETION_STEPS <= 16'd1;
        end else begin
            if (CONFIG_VALID) shadow_steps <= clamp_steps(COMPLETION_STEPS);
            if (start)        CALC_COMPLETION_STEPS <= shadow_steps;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)                                      SRC_ADDR <= '0;
        else if (start)                               SRC_ADDR <= '0;
        else if (state == FETCH && SRC_ADDR != LastAddr) SRC_ADDR <= SRC_ADDR + 1'b1;
    end

    // Source data lags the address by one cycle, and the stream is registered
    // once more, so element 0 and the frame-start strobe land together at s+2.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_d1       <= 1'b0;
            first_d1       <= 1'b0;
            CALC_DIN_VALID <= 1'b0;
            CALC_INTENSITY <= '0;
        end else begin
            fetch_d1       <= (state == FETCH);
            first_d1       <= (state == FETCH) && (SRC_ADDR == '0);
            CALC_DIN_VALID <= first_d1;
            if (fetch_d1) CALC_INTENSITY <= SRC_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            beat_cnt <= '0;
        end else if (start) begin
            beat_cnt <= '0;
        end else if ((state == FETCH || state == DRAIN) && CALC_DOUT_VALID && !beats_complete) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    silencer_frame_timeout #(
        .Width(16)
    ) u_timeout (
        .clk       (CLK),
        .rst       (RST),
        .load      (first_d1),
        .load_value(TimeoutLoad),
        .stop      (timer_stop),
        .expire    (expire)
    );

`ifdef SILENCER_OVERRUN_COUNT_EN
    always_ff @(posedge CLK) begin
        if (RST)                                         OVERRUN_COUNT <= '0;
        else if (UPDATE && pending && OVERRUN_COUNT != '1) OVERRUN_COUNT <= OVERRUN_COUNT + 1'b1;
    end
`endif

endmodule
